// File: rtl/clock_ctrl_pkg.sv
// Shared types and constants for the clock timekeeping / set-mode controller.
// The 12-hour display helpers are used only when TWELVE_HOUR_EN is defined.
package clock_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    SET_H = 2'd1,
    SET_M = 2'd2
  } mode_e;

  typedef logic [3:0] bcd_t;

  localparam int HOURS_MOD = 24;
  localparam int MINS_MOD  = 60;
  localparam int SECS_MOD  = 60;

  // Maps an internal 24-hour BCD hour to its 12-hour display digits {tens, units}.
  function automatic logic [7:0] hour_to_12h(input bcd_t tens, input bcd_t units);
    logic [7:0] h;
    h = {tens, units};
    case (h)
      8'h00:   hour_to_12h = 8'h12;
      8'h13:   hour_to_12h = 8'h01;
      8'h14:   hour_to_12h = 8'h02;
      8'h15:   hour_to_12h = 8'h03;
      8'h16:   hour_to_12h = 8'h04;
      8'h17:   hour_to_12h = 8'h05;
      8'h18:   hour_to_12h = 8'h06;
      8'h19:   hour_to_12h = 8'h07;
      8'h20:   hour_to_12h = 8'h08;
      8'h21:   hour_to_12h = 8'h09;
      8'h22:   hour_to_12h = 8'h10;
      8'h23:   hour_to_12h = 8'h11;
      default: hour_to_12h = h;
    endcase
  endfunction

  // Valid BCD orders the same as binary, so a byte compare is enough.
  function automatic logic hour_is_pm(input bcd_t tens, input bcd_t units);
    hour_is_pm = ({tens, units} >= 8'h12);
  endfunction

endpackage

// File: rtl/bcd2_counter.sv
// Two-digit BCD modulo-MOD counter with synchronous clear and a rollover flag.
// wrap is high in the cycle whose increment rolls the count back to 00.
module bcd2_counter
  import clock_ctrl_pkg::*;
#(
  parameter int MOD = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       inc,
  input  logic       clr,
  output logic [3:0] tens,
  output logic [3:0] units,
  output logic       wrap
);

  localparam bcd_t TENS_MAX  = 4'((MOD - 1) / 10);
  localparam bcd_t UNITS_MAX = 4'((MOD - 1) % 10);

  bcd_t tens_q, tens_d;
  bcd_t units_q, units_d;
  logic at_max;

  assign at_max = (tens_q == TENS_MAX) && (units_q == UNITS_MAX);

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    tens_d  = tens_q;
    units_d = units_q;
    if (clr) begin
      tens_d  = '0;
      units_d = '0;
    end else if (inc) begin
      if (at_max) begin
        tens_d  = '0;
        units_d = '0;
      end else if (units_q == 4'd9) begin
        tens_d  = tens_q + 4'd1;
        units_d = '0;
      end else begin
        units_d = units_q + 4'd1;
      end
    end
  end

  // NOTE: state is updated with non-blocking assignments so all flops sample together.
  always_ff @(posedge clk) begin
    if (rst) begin
      tens_q  <= '0;
      units_q <= '0;
    end else begin
      tens_q  <= tens_d;
      units_q <= units_d;
    end
  end

  assign tens  = tens_q;
  assign units = units_q;
  assign wrap  = inc && !clr && at_max;

endmodule

// File: rtl/clock_time_ctrl.sv
// 1 Hz timekeeping in BCD with a RUN -> SET_H -> SET_M button-driven set mode.
// Define TWELVE_HOUR_EN to add the pm output and a 12-hour hours display.
module clock_time_ctrl
  import clock_ctrl_pkg::*;
#(
  parameter int CLK_HZ = 27000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic [3:0] hh,
  output logic [3:0] hl,
  output logic [3:0] mh,
  output logic [3:0] ml,
  output logic [3:0] sh,
  output logic [3:0] sl,
  output logic       dots_on,
  output logic       hide_h,
  output logic       hide_m,
  output logic [1:0] mode
`ifdef TWELVE_HOUR_EN
  ,
  output logic       pm
`endif
);

  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] TERM = PW'(CLK_HZ - 1);
  localparam logic [PW-1:0] HALF = PW'(CLK_HZ / 2);

  mode_e         mode_q, mode_d;
  logic [PW-1:0] presc_q, presc_d;

  logic sec_tick, half;
  logic presc_clr, sec_clr, run_tick, hrs_set_inc, min_set_inc;
  logic sec_wrap, min_wrap, hrs_wrap_unused;
  logic min_inc, hrs_inc;
  bcd_t hrs_t, hrs_u;

  assign sec_tick = (presc_q == TERM);
  assign half     = (presc_q >= HALF);

  // btn_mode outranks btn_inc, and either outranks the seconds tick.
  always_comb begin
    mode_d      = mode_q;
    presc_clr   = 1'b0;
    sec_clr     = 1'b0;
    run_tick    = 1'b0;
    hrs_set_inc = 1'b0;
    min_set_inc = 1'b0;
    if (btn_mode) begin
      case (mode_q)
        RUN:     mode_d = SET_H;
        SET_H:   mode_d = SET_M;
        default: begin
          mode_d    = RUN;
          sec_clr   = 1'b1;
          presc_clr = 1'b1;
        end
      endcase
    end else if (btn_inc && mode_q == SET_H) begin
      hrs_set_inc = 1'b1;
      presc_clr   = 1'b1;
    end else if (btn_inc && mode_q == SET_M) begin
      min_set_inc = 1'b1;
      presc_clr   = 1'b1;
    end else if (mode_q == RUN) begin
      run_tick = sec_tick;
    end
    presc_d = (presc_clr || sec_tick) ? '0 : presc_q + PW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q  <= RUN;
      presc_q <= '0;
    end else begin
      mode_q  <= mode_d;
      presc_q <= presc_d;
    end
  end

  // Carries chain only on a RUN tick; set-mode increments never ripple upward.
  assign min_inc = min_set_inc | (run_tick & sec_wrap);
  assign hrs_inc = hrs_set_inc | (run_tick & min_wrap);

  bcd2_counter #(.MOD(SECS_MOD)) u_secs (
    .clk   (clk),
    .rst   (rst),
    .inc   (run_tick),
    .clr   (sec_clr),
    .tens  (sh),
    .units (sl),
    .wrap  (sec_wrap)
  );

  bcd2_counter #(.MOD(MINS_MOD)) u_mins (
    .clk   (clk),
    .rst   (rst),
    .inc   (min_inc),
    .clr   (1'b0),
    .tens  (mh),
    .units (ml),
    .wrap  (min_wrap)
  );

  bcd2_counter #(.MOD(HOURS_MOD)) u_hrs (
    .clk   (clk),
    .rst   (rst),
    .inc   (hrs_inc),
    .clr   (1'b0),
    .tens  (hrs_t),
    .units (hrs_u),
    .wrap  (hrs_wrap_unused)
  );

`ifdef TWELVE_HOUR_EN
  assign {hh, hl} = hour_to_12h(hrs_t, hrs_u);
  assign pm       = hour_is_pm(hrs_t, hrs_u);
`else
  assign hh = hrs_t;
  assign hl = hrs_u;
`endif

  assign mode    = mode_q;
  assign dots_on = (mode_q == RUN) ? !half : 1'b1;
  assign hide_h  = (mode_q == SET_H) && half;
  assign hide_m  = (mode_q == SET_M) && half;

endmodule

// File: tb/tb_clock_time_ctrl.sv
// Randomized scoreboard bench for clock_time_ctrl; the model keeps time as
// seconds-of-day. Define TWELVE_HOUR_EN for both DUT and bench to cover pm.
module tb_clock_time_ctrl;

  localparam int CLK_HZ = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_mode = 1'b0;
  logic       btn_inc = 1'b0;
  logic [3:0] hh, hl, mh, ml, sh, sl;
  logic       dots_on, hide_h, hide_m;
  logic [1:0] mode;
`ifdef TWELVE_HOUR_EN
  logic       pm;
`endif

  clock_time_ctrl #(.CLK_HZ(CLK_HZ)) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_mode (btn_mode),
    .btn_inc  (btn_inc),
    .hh       (hh),
    .hl       (hl),
    .mh       (mh),
    .ml       (ml),
    .sh       (sh),
    .sl       (sl),
    .dots_on  (dots_on),
    .hide_h   (hide_h),
    .hide_m   (hide_m),
    .mode     (mode)
`ifdef TWELVE_HOUR_EN
    ,
    .pm       (pm)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] cyc;
    logic [3:0]  hh, hl, mh, ml, sh, sl;
    logic        dots, hide_h, hide_m;
    logic [1:0]  mode;
    logic        pm;
  } obs_t;

  obs_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  bit   stim_done = 1'b0;

  // Reference model: seconds of day, prescaler phase, mode number.
  int m_t = 0;
  int m_p = 0;
  int m_m = 0;

  function automatic int m_hour();
    return m_t / 3600;
  endfunction

  function automatic int m_min();
    return (m_t / 60) % 60;
  endfunction

  function automatic obs_t model_obs();
    obs_t o;
    int   h, mi, s, hd;
    h  = m_t / 3600;
    mi = (m_t / 60) % 60;
    s  = m_t % 60;
    hd = h;
`ifdef TWELVE_HOUR_EN
    hd = (h % 12 == 0) ? 12 : h % 12;
`endif
    o.cyc    = 32'(cyc);
    o.hh     = 4'(hd / 10);
    o.hl     = 4'(hd % 10);
    o.mh     = 4'(mi / 10);
    o.ml     = 4'(mi % 10);
    o.sh     = 4'(s / 10);
    o.sl     = 4'(s % 10);
    o.dots   = (m_m != 0) || (m_p < CLK_HZ / 2);
    o.hide_h = (m_m == 1) && (m_p >= CLK_HZ / 2);
    o.hide_m = (m_m == 2) && (m_p >= CLK_HZ / 2);
    o.mode   = 2'(m_m);
`ifdef TWELVE_HOUR_EN
    o.pm     = (h >= 12);
`else
    o.pm     = 1'b0;
`endif
    return o;
  endfunction

  task automatic model_update(input bit r, input bit bm, input bit bi);
    bit tick;
    int np;
    if (r) begin
      m_t = 0;
      m_p = 0;
      m_m = 0;
    end else begin
      tick = (m_p == CLK_HZ - 1);
      np   = tick ? 0 : m_p + 1;
      if (bm) begin
        if (m_m == 2) begin
          m_t = m_t - m_t % 60;
          np  = 0;
        end
        m_m = (m_m + 1) % 3;
      end else if (bi && m_m == 1) begin
        m_t = ((m_hour() + 1) % 24) * 3600 + m_t % 3600;
        np  = 0;
      end else if (bi && m_m == 2) begin
        m_t = m_hour() * 3600 + ((m_min() + 1) % 60) * 60 + m_t % 60;
        np  = 0;
      end else if (m_m == 0 && tick) begin
        m_t = (m_t + 1) % 86400;
      end
      m_p = np;
    end
  endtask

  task automatic check(input string name, input obs_t act, input obs_t req);
    checks++;
    if (act !== req) begin
      errors++;
      if (errors <= 30)
        $display("FAIL %s: got %h%h:%h%h:%h%h dots=%b hide_h=%b hide_m=%b mode=%0d pm=%b, expected %h%h:%h%h:%h%h dots=%b hide_h=%b hide_m=%b mode=%0d pm=%b",
                 name, act.hh, act.hl, act.mh, act.ml, act.sh, act.sl, act.dots, act.hide_h,
                 act.hide_m, act.mode, act.pm, req.hh, req.hl, req.mh, req.ml, req.sh, req.sl,
                 req.dots, req.hide_h, req.hide_m, req.mode, req.pm);
    end
  endtask

  // Drive one cycle of inputs and queue what the DUT should show after the next edge.
  task automatic step(input bit r, input bit bm, input bit bi);
    @(negedge clk);
    rst      = r;
    btn_mode = bm;
    btn_inc  = bi;
    model_update(r, bm, bi);
    cyc++;
    exp_q.push_back(model_obs());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic press_mode();
    step(1'b0, 1'b1, 1'b0);
    idle(int'($urandom_range(0, 3)));
  endtask

  task automatic press_inc();
    step(1'b0, 1'b0, 1'b1);
    idle(int'($urandom_range(0, 12)));
  endtask

  // Monitor: compares one queued expectation per clock, sampled after the edge.
  initial begin : monitor
    obs_t e, a;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e      = exp_q.pop_front();
        a.cyc  = e.cyc;
        a.hh   = hh;
        a.hl   = hl;
        a.mh   = mh;
        a.ml   = ml;
        a.sh   = sh;
        a.sl   = sl;
        a.dots = dots_on;
        a.hide_h = hide_h;
        a.hide_m = hide_m;
        a.mode = mode;
`ifdef TWELVE_HOUR_EN
        a.pm   = pm;
`else
        a.pm   = 1'b0;
`endif
        check($sformatf("cycle_%0d", e.cyc), a, e);
      end
    end
  end

  initial begin : stimulus
    int r;
    repeat (3) step(1'b1, 1'b0, 1'b0);

    // Free run past the first minute boundary.
    idle(605);

    // Preload 23:59 through set mode, then run through midnight.
    press_mode();
    while (m_hour() != 23) press_inc();
    press_mode();
    while (m_min() != 59) press_inc();
    press_mode();
    idle(600);

    // SET_H: reach 05, then a full 24-press lap back to 05.
    press_mode();
    while (m_hour() != 5) press_inc();
    repeat (24) press_inc();
    // Simultaneous buttons: mode wins, hours unchanged.
    step(1'b0, 1'b1, 1'b1);
    idle(3);
    // SET_M: walk to 59, then one press wraps to 00 with no hour carry.
    while (m_min() != 59) press_inc();
    press_inc();
    press_mode();
    idle(30);

    // Random traffic, including presses landing on the tick cycle and resets.
    for (int i = 0; i < 3000; i++) begin
      r = int'($urandom_range(0, 999));
      step(r < 2, (r >= 2) && (r < 30), $urandom_range(0, 7) == 0);
    end
    while (m_m != 0) press_mode();

    // Reach 12:34:56 and reset mid-second.
    press_mode();
    while (m_hour() != 12) press_inc();
    press_mode();
    while (m_min() != 34) press_inc();
    press_mode();
    while (m_t % 60 != 56) idle(1);
    idle(3);
    step(1'b1, 1'b0, 1'b0);
    idle(12);
    stim_done = 1'b1;
  end

  initial begin : finisher
    int budget;
    budget = 0;
    while (!stim_done && budget < 90000) begin
      @(posedge clk);
      budget++;
    end
    if (!stim_done) begin
      errors++;
      checks++;
      $display("FAIL stimulus_timeout: got running after %0d cycles, expected done", budget);
    end
    repeat (4) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
